// File: rtl/bcd_pkg.sv
// Shared types and helpers for the two-digit BCD counter.
// The decade step function is shared by the digit registers and the tc lookahead.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Next state of one decade.
  // A code above 9 always collapses to 0, whatever the carry-in.
  function automatic bcd_digit_t digit_next(input bcd_digit_t q, input logic cin,
                                            input logic clr);
    bcd_digit_t n;
    n = q;
    if (clr || (q > BCD_MAX))
      n = BCD_ZERO;
    else if (cin)
      n = (q == BCD_MAX) ? BCD_ZERO : q + 4'd1;
    return n;
  endfunction

  // Binary value of a {tens, units} pair (tens*10 + units).
  function automatic logic [7:0] bcd_to_bin(input bcd_digit_t msb, input bcd_digit_t lsb);
    return ({4'd0, msb} << 3) + ({4'd0, msb} << 1) + {4'd0, lsb};
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter (0..9) with asynchronous active-high reset.
// Steps when cin=1; clr forces 0 on the next edge; cout = cin & (q==9).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cin,
  input  logic       clr,
  output bcd_digit_t q,
  output logic       cout
);

  bcd_digit_t r_q;
  bcd_digit_t w_d;

  assign w_d  = digit_next(r_q, cin, clr);
  assign q    = r_q;
  // An illegal code produces no carry because it never compares equal to 9.
  assign cout = cin & (r_q == BCD_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= BCD_ZERO;
    else       r_q <= w_d;
  end

endmodule

// File: rtl/bcd.sv
// Free-running two-digit BCD counter, 0..MOD_VALUE-1, one step per clock.
// Define BCD_TC_EN to add the registered terminal-count output tc.
module bcd
  import bcd_pkg::*;
#(
  parameter int MOD_VALUE = 100
) (
  input  logic       clk,
  input  logic       reset,
  output bcd_digit_t bcd_lsb,
  output bcd_digit_t bcd_msb
`ifdef BCD_TC_EN
  ,
  output logic       tc
`endif
);

  localparam logic [7:0] LAST = 8'(MOD_VALUE - 1);

  if ((MOD_VALUE < 2) || (MOD_VALUE > 100)) begin : g_bad_mod
    $error("bcd: MOD_VALUE must be in 2..100");
  end

  bcd_digit_t w_lsb_q;
  bcd_digit_t w_msb_q;
  logic       w_lsb_cout;
  logic       w_msb_cout;
  logic       w_legal;
  logic       w_wrap;
  logic       w_clr;

  assign w_legal = (w_lsb_q <= BCD_MAX) && (w_msb_q <= BCD_MAX);
  assign w_wrap  = w_legal && (bcd_to_bin(w_msb_q, w_lsb_q) == LAST);
  // The tens carry-out only fires at 99, which for a short modulus is an
  // out-of-range count anyway; clearing both digits there is the natural wrap.
  assign w_clr   = w_wrap | w_msb_cout;

  bcd_digit u_lsb (
    .clk   (clk),
    .reset (reset),
    .cin   (1'b1),
    .clr   (w_clr),
    .q     (w_lsb_q),
    .cout  (w_lsb_cout)
  );

  bcd_digit u_msb (
    .clk   (clk),
    .reset (reset),
    .cin   (w_lsb_cout),
    .clr   (w_clr),
    .q     (w_msb_q),
    .cout  (w_msb_cout)
  );

  assign bcd_lsb = w_lsb_q;
  assign bcd_msb = w_msb_q;

`ifdef BCD_TC_EN
  // tc is a lookahead on the digits' next state so it lands on the same edge.
  logic w_tc_nxt;
  logic r_tc;

  assign w_tc_nxt = (bcd_to_bin(digit_next(w_msb_q, w_lsb_cout, w_clr),
                                digit_next(w_lsb_q, 1'b1, w_clr)) == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tc <= 1'b0;
    else       r_tc <= w_tc_nxt;
  end

  assign tc = r_tc;
`endif

endmodule

// File: tb/tb_bcd.sv
// Directed bench for bcd: modulus-100 and modulus-60 instances on a shared clock,
// table-driven checkpoints plus reset and long-run sequences.
module tb_bcd;

  logic       clk;
  logic       reset;
  logic [3:0] lsb, msb, lsb60, msb60;
`ifdef BCD_TC_EN
  logic       tc, tc60;
`endif

  bcd #(.MOD_VALUE(100)) dut (
    .clk     (clk),
    .reset   (reset),
    .bcd_lsb (lsb),
    .bcd_msb (msb)
`ifdef BCD_TC_EN
    ,
    .tc      (tc)
`endif
  );

  bcd #(.MOD_VALUE(60)) dut60 (
    .clk     (clk),
    .reset   (reset),
    .bcd_lsb (lsb60),
    .bcd_msb (msb60)
`ifdef BCD_TC_EN
    ,
    .tc      (tc60)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] l, m;
    logic       t;
    logic [3:0] l60, m60;
    logic       t60;
  } vec_t;

  vec_t vecs[12];
  int   n_chk = 0;
  int   n_err = 0;
  int   cnt   = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input int v100, input int v60);
    chk({nm, " lsb"},   {4'd0, lsb},   8'(v100 % 10));
    chk({nm, " msb"},   {4'd0, msb},   8'(v100 / 10));
    chk({nm, " lsb60"}, {4'd0, lsb60}, 8'(v60 % 10));
    chk({nm, " msb60"}, {4'd0, msb60}, 8'(v60 / 10));
`ifdef BCD_TC_EN
    chk({nm, " tc"},   {7'd0, tc},   {7'd0, v100 == 99});
    chk({nm, " tc60"}, {7'd0, tc60}, {7'd0, v60 == 59});
`endif
  endtask

  initial begin
    // edges after release -> {lsb, msb, tc} for mod 100 and mod 60
    vecs[0]  = '{1,   4'd1, 4'd0, 1'b0, 4'd1, 4'd0, 1'b0};
    vecs[1]  = '{9,   4'd9, 4'd0, 1'b0, 4'd9, 4'd0, 1'b0};
    vecs[2]  = '{10,  4'd0, 4'd1, 1'b0, 4'd0, 4'd1, 1'b0};
    vecs[3]  = '{21,  4'd1, 4'd2, 1'b0, 4'd1, 4'd2, 1'b0};
    vecs[4]  = '{50,  4'd0, 4'd5, 1'b0, 4'd0, 4'd5, 1'b0};
    vecs[5]  = '{59,  4'd9, 4'd5, 1'b0, 4'd9, 4'd5, 1'b1};
    vecs[6]  = '{60,  4'd0, 4'd6, 1'b0, 4'd0, 4'd0, 1'b0};
    vecs[7]  = '{98,  4'd8, 4'd9, 1'b0, 4'd8, 4'd3, 1'b0};
    vecs[8]  = '{99,  4'd9, 4'd9, 1'b1, 4'd9, 4'd3, 1'b0};
    vecs[9]  = '{100, 4'd0, 4'd0, 1'b0, 4'd0, 4'd4, 1'b0};
    vecs[10] = '{101, 4'd1, 4'd0, 1'b0, 4'd1, 4'd4, 1'b0};
    vecs[11] = '{120, 4'd0, 4'd2, 1'b0, 4'd0, 4'd0, 1'b0};

    // Reset 0..16 ns, released just after the 15 ns edge; first count at 25 ns.
    reset = 1'b1;
    #12;
    chk_all("in reset", 0, 0);
    #4;
    reset = 1'b0;
    #2;
    chk_all("after release", 0, 0);

    foreach (vecs[i]) begin
      while (cnt < vecs[i].n) begin
        tick();
        cnt++;
      end
      chk($sformatf("vec%0d lsb", i),   {4'd0, lsb},   {4'd0, vecs[i].l});
      chk($sformatf("vec%0d msb", i),   {4'd0, msb},   {4'd0, vecs[i].m});
      chk($sformatf("vec%0d lsb60", i), {4'd0, lsb60}, {4'd0, vecs[i].l60});
      chk($sformatf("vec%0d msb60", i), {4'd0, msb60}, {4'd0, vecs[i].m60});
`ifdef BCD_TC_EN
      chk($sformatf("vec%0d tc", i),   {7'd0, tc},   {7'd0, vecs[i].t});
      chk($sformatf("vec%0d tc60", i), {7'd0, tc60}, {7'd0, vecs[i].t60});
`endif
    end

    // Long run: every edge checked against the decimal model, up to count 321.
    while (cnt < 321) begin
      tick();
      cnt++;
      chk($sformatf("run%0d lsb range", cnt), {7'd0, lsb <= 4'd9}, 8'd1);
      chk($sformatf("run%0d msb range", cnt), {7'd0, msb <= 4'd9}, 8'd1);
      chk_all($sformatf("run%0d", cnt), cnt % 100, cnt % 60);
    end

    // Mid-count reset pulse at count 21: clears before the next edge.
    #2;
    reset = 1'b1;
    #1;
    chk_all("async reset", 0, 0);
    #7;
    chk_all("reset held over edge", 0, 0);
    #3;
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_all($sformatf("restart%0d", k), k, k);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
